// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (fetch / data) arbiter onto a single memory port.
// One transaction outstanding at a time; data has priority unless fetch has
// lost MAX_WAIT consecutive arbitrations. Fetch responses can be discarded
// with if_flush while the fetch transaction is in flight.
module mem_arbiter #(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    // fetch requester
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    // data requester
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    // memory port
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_owner_if;   // 1 = fetch owns the current transaction
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_starve_cnt;
    logic        r_drop;

    logic        r_if_gnt;
    logic        r_d_gnt;
    logic        r_if_rvalid;
    logic        r_d_rvalid;
    logic [31:0] r_if_rdata;
    logic [31:0] r_d_rdata;

    logic        w_grant_if;
    logic        w_grant_d;
    logic        w_rsp;
    logic        w_if_deliver;
    logic        w_d_deliver;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic, arbitration and response acceptance
    always_comb begin
        w_next       = r_state;
        w_grant_if   = 1'b0;
        w_grant_d    = 1'b0;
        w_rsp        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (if_req && (!d_req || (r_starve_cnt == LP_MAX_WAIT))) begin
                    w_grant_if = 1'b1;
                    w_next     = S_ISSUE;
                end else if (d_req) begin
                    w_grant_d  = 1'b1;
                    w_next     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (mem_gnt) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    w_rsp  = 1'b1;
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        // a flush in the same cycle as the response still discards it
        w_if_deliver = w_rsp && r_owner_if && !r_drop && !if_flush;
        w_d_deliver  = w_rsp && !r_owner_if;
    end

    // Grant pulses and latched memory command
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_if_gnt   <= 1'b0;
            r_d_gnt    <= 1'b0;
            r_owner_if <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
        end else begin
            r_if_gnt <= w_grant_if;
            r_d_gnt  <= w_grant_d;
            if (w_grant_if) begin
                r_owner_if <= 1'b1;
                r_we       <= 1'b0;
                r_addr     <= if_addr;
                r_wdata    <= '0;
            end else if (w_grant_d) begin
                r_owner_if <= 1'b0;
                r_we       <= d_we;
                r_addr     <= d_addr;
                r_wdata    <= d_wdata;
            end
        end
    end

    // Fetch starvation counter and fetch-response drop flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
            r_drop       <= 1'b0;
        end else begin
            if (w_grant_if) begin
                r_starve_cnt <= '0;
            end else if (w_grant_d && if_req && (r_starve_cnt != LP_MAX_WAIT)) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end

            if ((r_state == S_IDLE) || w_rsp) begin
                r_drop <= 1'b0;
            end else if (r_owner_if && if_flush) begin
                r_drop <= 1'b1;
            end
        end
    end

    // Response capture and rvalid pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_if_rvalid <= 1'b0;
            r_d_rvalid  <= 1'b0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
        end else begin
            r_if_rvalid <= w_if_deliver;
            r_d_rvalid  <= w_d_deliver;
            if (w_if_deliver) begin
                r_if_rdata <= mem_rdata;
            end
            if (w_d_deliver) begin
                r_d_rdata <= r_we ? '0 : mem_rdata;
            end
        end
    end

    assign if_gnt    = r_if_gnt;
    assign d_gnt     = r_d_gnt;
    assign if_rvalid = r_if_rvalid;
    assign d_rvalid  = r_d_rvalid;
    assign if_rdata  = r_if_rdata;
    assign d_rdata   = r_d_rdata;
    assign mem_req   = (r_state == S_ISSUE);
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

endmodule
